// File: rtl/sequence_presenter_pkg.sv
// sequence_presenter_pkg: shared state codes (also db_estado values) and default sizes/timings.
package sequence_presenter_pkg;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 4;
  localparam int DEF_T_ON = 1000;
  localparam int DEF_T_OFF = 500;
  typedef enum logic [3:0] {
    OCIOSO  = 4'd0,
    CARREGA = 4'd1,
    ACESO   = 4'd2,
    APAGADO = 4'd3,
    FIM     = 4'd4
  } state_t;
  function automatic int timer_w(int t_on, int t_off);
    return $clog2((t_on > t_off ? t_on : t_off) + 1);
  endfunction
endpackage

// File: rtl/sequence_presenter_if.sv
// sequence_presenter_if: control handshake, memory port and LED outputs of the presenter.
interface sequence_presenter_if
  import sequence_presenter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();
  logic              mostrar;
  logic              cancelar;
  logic [ADDR_W-1:0] limite;
  logic [DATA_W-1:0] mem_dado;
  logic [ADDR_W-1:0] mem_endereco;
  logic [DATA_W-1:0] leds;
  logic              ativo;
  logic              pronto;
  logic [3:0]        db_estado;
  modport master (
    output mostrar, cancelar, limite, mem_dado,
    input  mem_endereco, leds, ativo, pronto, db_estado
  );
  modport slave (
    input  mostrar, cancelar, limite, mem_dado,
    output mem_endereco, leds, ativo, pronto, db_estado
  );
endinterface

// File: rtl/presenter_timer.sv
// presenter_timer: up-counter with clear that saturates at, and flags, a terminal value.
module presenter_timer #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic [W-1:0] term,
  output logic         tc
);
  logic [W-1:0] cnt_q, cnt_d;
  assign tc = cnt_q == term;
  assign cnt_d = clr ? '0 : tc ? cnt_q : cnt_q + 1'b1;
  always_ff @(posedge clock) cnt_q <= reset ? '0 : cnt_d;
endmodule

// File: rtl/sequence_presenter.sv
// sequence_presenter: replays memory entries 0..limite on the LEDs, each lit T_ON then dark T_OFF.
module sequence_presenter
  import sequence_presenter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int T_ON = DEF_T_ON,
  parameter int T_OFF = DEF_T_OFF
) (
  input logic clock,
  input logic reset,
  sequence_presenter_if.slave bus
);
  localparam int TW = timer_w(T_ON, T_OFF);
  state_t            st_q, st_d;
  logic [ADDR_W-1:0] addr_q, addr_d, lim_q, lim_d;
  logic [DATA_W-1:0] leds_q, leds_d;
  logic              pronto_q, pronto_d;
  logic [TW-1:0]     term;
  logic              tc, tclr;
  always_comb begin
    st_d = st_q;
    addr_d = addr_q;
    lim_d = lim_q;
    leds_d = leds_q;
    pronto_d = 1'b0;
    if (bus.cancelar && st_q != OCIOSO) begin
      st_d = OCIOSO;
      addr_d = '0;
      leds_d = '0;
    end else begin
      case (st_q)
        OCIOSO: if (bus.mostrar) begin
          st_d = CARREGA;
          addr_d = '0;
          lim_d = bus.limite;
        end
        CARREGA: if (tc) begin
          st_d = ACESO;
          leds_d = bus.mem_dado;
        end
        ACESO: if (tc) begin
          st_d = APAGADO;
          leds_d = '0;
        end
        APAGADO: if (tc) begin
          st_d = addr_q == lim_q ? FIM : CARREGA;
          addr_d = addr_q == lim_q ? addr_q : addr_q + 1'b1;
          pronto_d = addr_q == lim_q;
        end
        default: st_d = OCIOSO;
      endcase
    end
  end
  // CARREGA waits two cycles so the registered memory read has landed
  assign term = st_q == CARREGA ? TW'(1) : st_q == ACESO ? TW'(T_ON - 1) : TW'(T_OFF - 1);
  assign tclr = st_d != st_q || st_q == OCIOSO;
  presenter_timer #(.W(TW)) u_timer (
    .clock(clock),
    .reset(reset),
    .clr(tclr),
    .term(term),
    .tc(tc)
  );
  always_ff @(posedge clock) begin
    if (reset) begin
      st_q <= OCIOSO;
      addr_q <= '0;
      lim_q <= '0;
      leds_q <= '0;
      pronto_q <= 1'b0;
    end else begin
      st_q <= st_d;
      addr_q <= addr_d;
      lim_q <= lim_d;
      leds_q <= leds_d;
      pronto_q <= pronto_d;
    end
  end
  assign bus.mem_endereco = addr_q;
  assign bus.leds = leds_q;
  assign bus.pronto = pronto_q;
  assign bus.ativo = st_q != OCIOSO;
  assign bus.db_estado = st_q;
endmodule

// File: tb/tb_sequence_presenter.sv
// tb_sequence_presenter: directed vectors plus per-cycle timing checks with T_ON=4, T_OFF=2.
module tb_sequence_presenter;
  typedef struct {
    logic [3:0] leds;
    logic       ativo;
    logic       pronto;
    logic [3:0] db;
    logic [3:0] addr;
  } exp_t;
  typedef struct {
    logic       r;
    logic       m;
    logic       c;
    logic [3:0] lim;
    exp_t       e;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] mem[16];
  int checks = 0;
  int errors = 0;
  vec_t vt[13];
  sequence_presenter_if #(.ADDR_W(4), .DATA_W(4)) bus ();
  sequence_presenter #(.ADDR_W(4), .DATA_W(4), .T_ON(4), .T_OFF(2)) dut (
    .clock(clk),
    .reset(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) bus.mem_dado <= mem[bus.mem_endereco];
  function automatic exp_t mk(int leds, int ativo, int pronto, int db, int addr);
    exp_t e;
    e.leds = 4'(leds);
    e.ativo = 1'(ativo);
    e.pronto = 1'(pronto);
    e.db = 4'(db);
    e.addr = 4'(addr);
    return e;
  endfunction
  function automatic vec_t v(int r, int m, int c, int lim, exp_t e);
    vec_t x;
    x.r = 1'(r);
    x.m = 1'(m);
    x.c = 1'(c);
    x.lim = 4'(lim);
    x.e = e;
    return x;
  endfunction
  // k = edges since the start edge; each entry takes 2 load + 4 lit + 2 dark cycles
  function automatic exp_t expect_at(int k, int n);
    int i = k / 8;
    int j = k % 8;
    if (k < 8 * n)
      return mk((j >= 2 && j < 6) ? int'(mem[i]) : 0, 1, 0, j < 2 ? 1 : j < 6 ? 2 : 3, i);
    if (k == 8 * n) return mk(0, 1, 1, 4, n - 1);
    return mk(0, 0, 0, 0, n - 1);
  endfunction
  task automatic cmp(string name, int k, int act, int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s k=%0d: got %0h, want %0h", name, k, act, want);
    end
  endtask
  task automatic check(string tag, int k, exp_t e);
    cmp({tag, ".leds"}, k, int'(bus.leds), int'(e.leds));
    cmp({tag, ".ativo"}, k, int'(bus.ativo), int'(e.ativo));
    cmp({tag, ".pronto"}, k, int'(bus.pronto), int'(e.pronto));
    cmp({tag, ".db_estado"}, k, int'(bus.db_estado), int'(e.db));
    cmp({tag, ".mem_endereco"}, k, int'(bus.mem_endereco), int'(e.addr));
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic start(string tag, int lim);
    bus.limite = 4'(lim);
    bus.mostrar = 1'b1;
    tick();
    bus.mostrar = 1'b0;
    check(tag, 0, expect_at(0, lim + 1));
  endtask
  task automatic run(string tag, int n, int k0, int k1);
    for (int k = k0; k <= k1; k++) begin
      tick();
      check(tag, k, expect_at(k, n));
    end
  endtask
  initial begin
    bus.mostrar = 1'b0;
    bus.cancelar = 1'b0;
    bus.limite = 4'd0;
    for (int i = 0; i < 16; i++) mem[i] = 4'(1 << (i % 4));
    vt[0]  = v(1, 0, 0, 0, mk(0, 0, 0, 0, 0));
    vt[1]  = v(1, 0, 0, 0, mk(0, 0, 0, 0, 0));
    vt[2]  = v(0, 0, 1, 0, mk(0, 0, 0, 0, 0));
    vt[3]  = v(0, 1, 0, 0, mk(0, 1, 0, 1, 0));
    vt[4]  = v(0, 0, 0, 5, mk(0, 1, 0, 1, 0));
    vt[5]  = v(0, 0, 0, 5, mk(1, 1, 0, 2, 0));
    vt[6]  = v(0, 0, 0, 5, mk(1, 1, 0, 2, 0));
    vt[7]  = v(0, 0, 0, 5, mk(1, 1, 0, 2, 0));
    vt[8]  = v(0, 0, 0, 5, mk(1, 1, 0, 2, 0));
    vt[9]  = v(0, 0, 0, 5, mk(0, 1, 0, 3, 0));
    vt[10] = v(0, 0, 0, 5, mk(0, 1, 0, 3, 0));
    vt[11] = v(0, 0, 0, 5, mk(0, 1, 1, 4, 0));
    vt[12] = v(0, 0, 0, 5, mk(0, 0, 0, 0, 0));
    foreach (vt[i]) begin
      rst = vt[i].r;
      bus.mostrar = vt[i].m;
      bus.cancelar = vt[i].c;
      bus.limite = vt[i].lim;
      tick();
      check($sformatf("vec%0d", i), i, vt[i].e);
    end
    bus.mostrar = 1'b0;
    bus.cancelar = 1'b0;
    // full four-entry run
    start("run4", 3);
    run("run4", 4, 1, 34);
    // cancel in the third lit phase, then restart from address 0
    start("cancel", 3);
    run("cancel", 4, 1, 19);
    bus.cancelar = 1'b1;
    tick();
    check("cancel_edge", 20, mk(0, 0, 0, 0, 0));
    bus.cancelar = 1'b0;
    for (int k = 21; k < 31; k++) begin
      tick();
      check("cancel_idle", k, mk(0, 0, 0, 0, 0));
    end
    start("restart", 3);
    run("restart", 4, 1, 33);
    // mostrar and limite changes while busy are ignored
    start("midrun", 3);
    run("midrun", 4, 1, 9);
    bus.mostrar = 1'b1;
    bus.limite = 4'd1;
    run("midrun", 4, 10, 12);
    bus.mostrar = 1'b0;
    run("midrun", 4, 13, 34);
    // reset inside the dark gap, then a full 16-entry run
    start("rst", 3);
    run("rst", 4, 1, 6);
    rst = 1'b1;
    tick();
    check("rst_edge", 7, mk(0, 0, 0, 0, 0));
    rst = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 4'(1 << ((i + 1) % 4));
    start("run16", 15);
    run("run16", 16, 1, 130);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
